// File: rtl/lsh_ctrl.sv
`default_nettype none
// ============================================================================
// lsh_ctrl - insert/query/clear sequencer in front of hash_table; a query
// scans count_bus for the best window. Optional LSH_CTRL_THRESHOLD_EN adds
// match_threshold / rsp_hit.  Rev 1.0
// ============================================================================
module lsh_ctrl #(
  parameter int SKETCH_SIZE         = 16,
  parameter int LOG2_NUM_OF_BUCKETS = 8,
  parameter int MAX_WINDOWS         = 1024,
  parameter int LOG2_MAX_WINDOWS    = 10
) (
  input  logic                           clk,
  input  logic                           reset_lsh_ctrl_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  input  logic [LOG2_NUM_OF_BUCKETS-1:0] cmd_sketch [0:SKETCH_SIZE-1],
  output logic                           reset_hash_table,
  output logic                           is_insert,
  output logic                           is_query,
  output logic [31:0]                    window_id,
  output logic [LOG2_NUM_OF_BUCKETS-1:0] hashed_sketch [0:SKETCH_SIZE-1],
  input  logic [31:0]                    count_bus [0:MAX_WINDOWS-1],
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_window_id,
  output logic [31:0]                    rsp_count,
  output logic                           rsp_error,
`ifdef LSH_CTRL_THRESHOLD_EN
  input  logic [31:0]                    match_threshold,
  output logic                           rsp_hit,
`endif
  output logic [LOG2_MAX_WINDOWS:0]      num_windows
);

  localparam int NW_W = LOG2_MAX_WINDOWS + 1;

  localparam logic [1:0] OP_INSERT = 2'b00;
  localparam logic [1:0] OP_QUERY  = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  // PEND is the reset value so the INIT clear strobe only fires after release.
  localparam logic [2:0] PEND  = 3'd0;
  localparam logic [2:0] INIT  = 3'd1;
  localparam logic [2:0] IDLE  = 3'd2;
  localparam logic [2:0] ISSUE = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;
  localparam logic [2:0] SCAN  = 3'd5;
  localparam logic [2:0] RESP  = 3'd6;

  logic [2:0]                  state;
  logic [1:0]                  op;
  logic [LOG2_MAX_WINDOWS-1:0] idx;
  logic [31:0]                 best_id;
  logic [31:0]                 best_cnt;
  logic                        err;
  logic                        full;
  logic                        last_idx;
`ifdef LSH_CTRL_THRESHOLD_EN
  logic [31:0]                 thr;
`endif

  assign full     = (num_windows == NW_W'(MAX_WINDOWS));
  assign last_idx = (({1'b0, idx} + NW_W'(1)) == num_windows);

  assign cmd_ready        = (state == IDLE);
  assign is_insert        = (state == ISSUE) && (op == OP_INSERT) && !full;
  assign is_query         = (state == ISSUE) && (op == OP_QUERY);
  assign reset_hash_table = (state == INIT) || ((state == ISSUE) && (op == OP_CLEAR));
  assign window_id        = is_insert ? 32'(num_windows) : 32'd0;

  // Response fields read as zero outside RESP so idle cycles carry no stale data.
  assign rsp_valid     = (state == RESP);
  assign rsp_window_id = rsp_valid ? best_id : 32'd0;
  assign rsp_count     = rsp_valid ? best_cnt : 32'd0;
  assign rsp_error     = rsp_valid && err;
`ifdef LSH_CTRL_THRESHOLD_EN
  assign rsp_hit       = rsp_valid && (op == OP_QUERY) && (best_cnt >= thr);
`endif

  always_ff @(posedge clk or negedge reset_lsh_ctrl_n) begin
    if (!reset_lsh_ctrl_n) begin
      state         <= PEND;
      op            <= 2'b00;
      idx           <= '0;
      best_id       <= 32'd0;
      best_cnt      <= 32'd0;
      err           <= 1'b0;
      num_windows   <= '0;
      hashed_sketch <= '{default: '0};
`ifdef LSH_CTRL_THRESHOLD_EN
      thr           <= 32'd0;
`endif
    end else begin
      case (state)
        PEND: state <= INIT;
        INIT: state <= IDLE;
        IDLE: begin
          if (cmd_valid) begin
            op            <= cmd_op;
            hashed_sketch <= cmd_sketch;
            best_id       <= 32'd0;
            best_cnt      <= 32'd0;
            err           <= 1'b0;
`ifdef LSH_CTRL_THRESHOLD_EN
            thr           <= match_threshold;
`endif
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          state <= RESP;
          case (op)
            OP_INSERT: begin
              if (full) begin
                err <= 1'b1;
              end else begin
                best_id     <= 32'(num_windows);
                num_windows <= num_windows + NW_W'(1);
              end
            end
            OP_QUERY: state       <= WAIT;
            OP_CLEAR: num_windows <= '0;
            default:  err         <= 1'b1;
          endcase
        end
        WAIT: begin
          best_id  <= 32'd0;
          best_cnt <= 32'd0;
          idx      <= '0;
          state    <= (num_windows == '0) ? RESP : SCAN;
        end
        SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (count_bus[idx] > best_cnt) begin
            best_cnt <= count_bus[idx];
            best_id  <= 32'(idx);
          end
          idx <= idx + LOG2_MAX_WINDOWS'(1);
          if (last_idx) state <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= PEND;
      endcase
    end
  end

endmodule
`default_nettype wire
